// File: rtl/xc20xx_clb_pkg.sv
// xc20xx_clb_pkg: shared types and helpers for the XC20XX CLB K-input LUT cell.
package xc20xx_clb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2
  } cfg_state_t;

  localparam int K_MAX = 6;

  // Truth-table width for a k-input LUT.
  function automatic int tt_width(input int k);
    return 32'd1 << k;
  endfunction

endpackage

// File: rtl/xc20xx_clb_lutk_if.sv
// xc20xx_clb_lutk_if: serial truth-table reload/readback port of the LUT cell.
interface xc20xx_clb_lutk_if;
  logic CFG_START;
  logic CFG_VALID;
  logic CFG_DIN;
  logic CFG_ABORT;
  logic CFG_BUSY;
  logic CFG_DONE;
  logic CFG_DOUT;

  modport master (
    output CFG_START, CFG_VALID, CFG_DIN, CFG_ABORT,
    input  CFG_BUSY, CFG_DONE, CFG_DOUT
  );

  modport slave (
    input  CFG_START, CFG_VALID, CFG_DIN, CFG_ABORT,
    output CFG_BUSY, CFG_DONE, CFG_DOUT
  );
endinterface

// File: rtl/xc20xx_lut_mux.sv
// xc20xx_lut_mux: combinational 2**K:1 mux tree. IN[K-1] picks the table half
// first and IN[0] makes the final 2:1 choice, so OUT == TT[IN].
module xc20xx_lut_mux
  import xc20xx_clb_pkg::*;
#(
  parameter int K = 4
) (
  input  logic [tt_width(K)-1:0] TT,
  input  logic [K-1:0]           IN,
  output logic                   OUT
);

  localparam int TW = tt_width(K);

  logic [TW-1:0] stage;

  // Fold the table in half once per select bit, most significant select first.
  always_comb begin
    stage = TT;
    for (int j = 0; j < K; j++) begin
      for (int i = 0; i < (TW >> (j + 1)); i++) begin
        stage[i] = IN[K-1-j] ? stage[i + (TW >> (j + 1))] : stage[i];
      end
    end
    OUT = stage[0];
  end

endmodule

// File: rtl/xc20xx_clb_lutk.sv
// xc20xx_clb_lutk: K-input LUT cell with optional output register and a serial
// truth-table reload port. The reload is staged in a shadow register and only
// copied into the live table in COMMIT, so the function never changes mid-load.
// Optional feature macro: XC20XX_CLB_READBACK_EN (old table shifts out on CFG_DOUT
// while the new one shifts in).
module xc20xx_clb_lutk
  import xc20xx_clb_pkg::*;
#(
  parameter int                    K        = 4,
  parameter logic [tt_width(K)-1:0] INIT    = '0,
  parameter int                    OUT_MODE = 0,
  parameter logic                  FF_INIT  = 1'b0
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic [K-1:0] IN,
  input  logic         CE,
  output logic         OUT,
  output logic         OUT_Q,
  xc20xx_clb_lutk_if.slave cfg
);

  localparam int         TW   = tt_width(K);
  localparam logic [K:0] LAST = (K+1)'(TW - 1);

  cfg_state_t    state;
  logic [TW-1:0] tt;
  logic [TW-1:0] shadow;
  logic [K:0]    cnt;
  logic          busy;
  logic          done;
  logic          lut;
  logic          out_q;

  xc20xx_lut_mux #(.K(K)) u_mux (
    .TT  (tt),
    .IN  (IN),
    .OUT (lut)
  );

  // Reload FSM: owns the live table, shadow register, bit counter and status flags.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state  <= IDLE;
      tt     <= INIT;
      shadow <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cfg.CFG_START) begin
            state <= LOAD;
            busy  <= 1'b1;
            cnt   <= '0;
`ifdef XC20XX_CLB_READBACK_EN
            shadow <= tt;
`else
            shadow <= '0;
`endif
          end
        end
        LOAD: begin
          // Abort has priority, including over the final bit.
          if (cfg.CFG_ABORT) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
          end else if (cfg.CFG_VALID) begin
            shadow <= {shadow[TW-2:0], cfg.CFG_DIN};
            cnt    <= cnt + 1'b1;
            if (cnt == LAST) begin
              state <= COMMIT;
              done  <= 1'b1;
            end
          end
        end
        COMMIT: begin
          tt    <= shadow;
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          cnt   <= '0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef XC20XX_CLB_READBACK_EN
  logic dout;

  // Readback: CFG_DOUT mirrors the shadow MSB while loading, 0 otherwise.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      dout <= 1'b0;
    end else if (state == IDLE) begin
      dout <= cfg.CFG_START ? tt[TW-1] : 1'b0;
    end else if (state == LOAD) begin
      if (cfg.CFG_ABORT || (cfg.CFG_VALID && (cnt == LAST))) begin
        dout <= 1'b0;
      end else if (cfg.CFG_VALID) begin
        dout <= shadow[TW-2];
      end else begin
        dout <= dout;
      end
    end else begin
      dout <= 1'b0;
    end
  end

  assign cfg.CFG_DOUT = dout;
`else
  assign cfg.CFG_DOUT = 1'b0;
`endif

  // Output register: samples the LUT value when enabled, holds otherwise.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      out_q <= FF_INIT;
    end else if (CE) begin
      out_q <= lut;
    end else begin
      out_q <= out_q;
    end
  end

  generate
    if (OUT_MODE == 1) begin : g_out_reg
      assign OUT = out_q;
    end else begin : g_out_comb
      assign OUT = lut;
    end
  endgenerate

  assign OUT_Q        = out_q;
  assign cfg.CFG_BUSY = busy;
  assign cfg.CFG_DONE = done;

endmodule

// File: tb/tb_xc20xx_clb_lutk.sv
// tb_xc20xx_clb_lutk: self-checking bench for the K=4 LUT cell. Instance A is
// combinational-output (INIT=16'h8000), instance B is registered-output with FF_INIT=1.
// Builds with or without XC20XX_CLB_READBACK_EN; readback expectations follow the macro.
module tb_xc20xx_clb_lutk;

  localparam logic [15:0] INIT_V = 16'h8000;
`ifdef XC20XX_CLB_READBACK_EN
  localparam logic RB = 1'b1;
`else
  localparam logic RB = 1'b0;
`endif

  typedef struct {
    logic [3:0] in;
    logic       exp_out;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_a, rst_b, ce_a, ce_b;
  logic [3:0] in_a, in_b;
  logic       out_a, q_a, out_b, q_b;
  logic [15:0] tt_a, tt_b;   // reference truth tables
  logic        qm_b;         // reference output register of B
  int tests = 0;
  int fails = 0;

  xc20xx_clb_lutk_if ifa ();
  xc20xx_clb_lutk_if ifb ();

  xc20xx_clb_lutk #(.K(4), .INIT(INIT_V), .OUT_MODE(0), .FF_INIT(1'b0)) u_a (
    .CLK(clk), .RST_N(rst_a), .IN(in_a), .CE(ce_a), .OUT(out_a), .OUT_Q(q_a), .cfg(ifa.slave)
  );

  xc20xx_clb_lutk #(.K(4), .INIT(INIT_V), .OUT_MODE(1), .FF_INIT(1'b1)) u_b (
    .CLK(clk), .RST_N(rst_b), .IN(in_b), .CE(ce_b), .OUT(out_b), .OUT_Q(q_b), .cfg(ifb.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic sweep_a(input string name);
    for (int i = 0; i < 16; i++) begin
      in_a = 4'(i);
      #1;
      check(name, out_a, tt_a[i]);
    end
  endtask

  // One observation cycle during a reload on A: old function, readback bit, status.
  task automatic probe_a(input logic exp_dout, inout int busy_n, inout int done_at, inout int done_n);
    in_a = 4'($urandom_range(0, 15));
    #1;
    check("lut_during_load", out_a, tt_a[in_a]);
    check("dout", ifa.CFG_DOUT, exp_dout);
    if (ifa.CFG_BUSY) busy_n++;
    if (ifa.CFG_DONE) begin
      done_n++;
      done_at = busy_n;
    end
  endtask

  // Full reload of A. gap_mode 0: none, 1: every other cycle, 2: random gaps.
  task automatic load_a(input logic [15:0] val, input int gap_mode);
    logic [15:0] old;
    int busy_n, done_at, done_n, extra;
    old = tt_a; busy_n = 0; done_at = 0; done_n = 0; extra = 0;
    ifa.CFG_START = 1'b1;
    step();
    for (int b = 15; b >= 0; b--) begin
      if (gap_mode == 1 || (gap_mode == 2 && $urandom_range(0, 1) == 1)) begin
        ifa.CFG_VALID = 1'b0;
        ifa.CFG_START = 1'($urandom_range(0, 1));
        extra++;
        probe_a(RB & old[b], busy_n, done_at, done_n);
        step();
      end
      ifa.CFG_VALID = 1'b1;
      ifa.CFG_DIN   = val[b];
      ifa.CFG_START = 1'($urandom_range(0, 1));
      probe_a(RB & old[b], busy_n, done_at, done_n);
      step();
    end
    ifa.CFG_VALID = 1'b0;
    ifa.CFG_START = 1'b0;
    ifa.CFG_ABORT = 1'b1;
    probe_a(1'b0, busy_n, done_at, done_n);
    step();
    ifa.CFG_ABORT = 1'b0;
    tt_a = val;
    #1;
    check("busy_cycles", busy_n, 17 + extra);
    check("done_count", done_n, 1);
    check("done_position", done_at, 17 + extra);
    check("busy_after_commit", ifa.CFG_BUSY, 1'b0);
    check("done_after_commit", ifa.CFG_DONE, 1'b0);
  endtask

  // Plain reload of B, checking only the DONE pulse.
  task automatic feed_b(input logic [15:0] val);
    ifb.CFG_START = 1'b1;
    step();
    ifb.CFG_START = 1'b0;
    for (int b = 15; b >= 0; b--) begin
      ifb.CFG_VALID = 1'b1;
      ifb.CFG_DIN   = val[b];
      step();
    end
    ifb.CFG_VALID = 1'b0;
    #1;
    check("b_done", ifb.CFG_DONE, 1'b1);
    step();
    tt_b = val;
  endtask

  task automatic rand_b(input int n);
    for (int i = 0; i < n; i++) begin
      in_b = 4'($urandom_range(0, 15));
      ce_b = 1'($urandom_range(0, 1));
      if (ce_b) qm_b = tt_b[in_b];
      step();
      #1;
      check("b_rand_out", out_b, qm_b);
      check("b_rand_q", q_b, qm_b);
    end
  endtask

  vec_t tbl [16];

  initial begin
    for (int i = 0; i < 16; i++) begin
      tbl[i].in      = 4'(i);
      tbl[i].exp_out = (i == 15) ? 1'b1 : 1'b0;
    end
    tt_a = INIT_V; tt_b = INIT_V; qm_b = 1'b1;
    rst_a = 1'b0; rst_b = 1'b0; ce_a = 1'b0; ce_b = 1'b0; in_a = 4'h0; in_b = 4'h0;
    ifa.CFG_START = 1'b0; ifa.CFG_VALID = 1'b0; ifa.CFG_DIN = 1'b0; ifa.CFG_ABORT = 1'b0;
    ifb.CFG_START = 1'b0; ifb.CFG_VALID = 1'b0; ifb.CFG_DIN = 1'b0; ifb.CFG_ABORT = 1'b0;
    step();
    step();
    rst_a = 1'b1; rst_b = 1'b1;
    #1;
    // Reset state
    check("rst_busy", ifa.CFG_BUSY, 1'b0);
    check("rst_done", ifa.CFG_DONE, 1'b0);
    check("rst_dout", ifa.CFG_DOUT, 1'b0);
    check("rst_qa", q_a, 1'b0);
    check("rst_out_b", out_b, 1'b1);
    check("rst_q_b", q_b, 1'b1);

    // 1: table-driven sweep of the AND function
    for (int i = 0; i < 16; i++) begin
      in_a = tbl[i].in;
      #1;
      check("and_sweep", out_a, tbl[i].exp_out);
    end

    // 2: parity load with VALID held high; old function and readback checked inside
    load_a(16'h6996, 0);
    in_a = 4'h1; #1; check("parity_1", out_a, 1'b1);
    in_a = 4'h3; #1; check("parity_3", out_a, 1'b0);
    sweep_a("parity_sweep");

    // 3: VALID gaps every other cycle, back to AND
    load_a(16'h8000, 1);
    sweep_a("gap_sweep");

    // 4a: abort after 8 bits
    ifa.CFG_START = 1'b1; step(); ifa.CFG_START = 1'b0;
    for (int n = 0; n < 8; n++) begin
      ifa.CFG_VALID = 1'b1; ifa.CFG_DIN = 1'($urandom_range(0, 1)); step();
    end
    ifa.CFG_VALID = 1'b0; ifa.CFG_ABORT = 1'b1;
    #1; check("abort8_busy_pre", ifa.CFG_BUSY, 1'b1);
    step(); ifa.CFG_ABORT = 1'b0;
    #1;
    check("abort8_busy", ifa.CFG_BUSY, 1'b0);
    check("abort8_done", ifa.CFG_DONE, 1'b0);
    check("abort8_dout", ifa.CFG_DOUT, 1'b0);
    step(); #1; check("abort8_no_late_done", ifa.CFG_DONE, 1'b0);
    sweep_a("abort8_sweep");

    // 4b: abort coincident with the 16th bit
    ifa.CFG_START = 1'b1; step(); ifa.CFG_START = 1'b0;
    for (int n = 0; n < 15; n++) begin
      ifa.CFG_VALID = 1'b1; ifa.CFG_DIN = 1'b0; step();
    end
    ifa.CFG_VALID = 1'b1; ifa.CFG_DIN = 1'b0; ifa.CFG_ABORT = 1'b1;
    step();
    ifa.CFG_VALID = 1'b0; ifa.CFG_ABORT = 1'b0;
    #1;
    check("abort16_busy", ifa.CFG_BUSY, 1'b0);
    check("abort16_done", ifa.CFG_DONE, 1'b0);
    step(); #1; check("abort16_no_late_done", ifa.CFG_DONE, 1'b0);
    sweep_a("abort16_sweep");

    // Abort in IDLE is ignored: START+ABORT still enters LOAD
    ifa.CFG_START = 1'b1; ifa.CFG_ABORT = 1'b1; step();
    ifa.CFG_START = 1'b0;
    #1; check("idle_abort_ignored", ifa.CFG_BUSY, 1'b1);
    step(); ifa.CFG_ABORT = 1'b0;
    #1; check("load_abort_exit", ifa.CFG_BUSY, 1'b0);

    // Randomized reloads with random gaps against the reference table
    for (int r = 0; r < 6; r++) begin
      load_a(16'($urandom), 2);
      sweep_a("rand_sweep");
    end

    // 5: registered output on B
    in_b = 4'h0; ce_b = 1'b0;
    for (int n = 0; n < 3; n++) begin
      step(); #1; check("b_hold", out_b, 1'b1);
    end
    ce_b = 1'b1;
    #1; check("b_late_pre", out_b, 1'b1);
    step(); #1; check("b_late_post", out_b, 1'b0);
    in_b = 4'hF;
    #1; check("b_f_pre", out_b, 1'b0);
    step(); #1; check("b_f_post", out_b, 1'b1);
    qm_b = 1'b1;
    rand_b(30);
    feed_b(16'h0001);
    rand_b(20);

    // Reset low mid-load: back to INIT, FF_INIT, IDLE
    ce_b = 1'b0;
    ifb.CFG_START = 1'b1; step(); ifb.CFG_START = 1'b0;
    for (int n = 0; n < 5; n++) begin
      ifb.CFG_VALID = 1'b1; ifb.CFG_DIN = 1'b1; step();
    end
    ifb.CFG_VALID = 1'b0;
    #2 rst_b = 1'b0;
    #1;
    check("b_rst_out", out_b, 1'b1);
    check("b_rst_q", q_b, 1'b1);
    check("b_rst_busy", ifb.CFG_BUSY, 1'b0);
    step();
    rst_b = 1'b1;
    tt_b = INIT_V; qm_b = 1'b1;
    #1; check("b_idle_after_rst", ifb.CFG_BUSY, 1'b0);
    ce_b = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_b = 4'(i);
      step(); #1;
      check("b_init_sweep", out_b, INIT_V[i]);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
